mem_port_arbiter: RTL and testbench

Shares the single 16-bit memory port between the CPU instruction-fetch unit and the load/store (data) unit.
- Grants one access at a time and drives memory with latched address and data.
- Waits a fixed memory read latency, then returns read data with a one-cycle ack.
- Data port has priority; a starvation guard guarantees fetch progress. A halt input from the control path blocks new grants.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_arb_starve_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package toast_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    // Width of the saturating starvation counter.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester handshakes and the shared memory port.
// Latency: none (wiring only).
// Backpressure: requesters hold req and payload until their ack pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    // data requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory view.
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of fetch losses, flags when the force-grant limit is hit.
// Latency: count updates one cycle after inc/clr; at_limit is combinational from the count.
// Backpressure: none; clr takes precedence over inc.
module mem_arb_starve_ctr
    import toast_mem_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [STARVE_W-1:0] cnt;

    // Saturating counter; holds at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    assign at_limit = (cnt == STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins unless fetch is starved.
// Latency: accept edge to ack cycle is 2+MEM_LATENCY cycles; one access per 3+MEM_LATENCY cycles.
// Backpressure: requests wait in IDLE until granted; halt blocks new grants but never aborts one in flight.
module mem_port_arbiter
    import toast_mem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    output logic              busy,
    mem_port_arbiter_if.master bus
);

    localparam int LAT_W = 3;

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_owner_t        owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic grant;
    logic grant_if;
    logic at_limit;
    logic starve_inc;
    logic starve_clr;
    logic last_wait;

    // Grants only come from IDLE, so a request still high during its own ack is not re-served.
    assign grant      = (state == IDLE) && !halt && (bus.if_req || bus.dm_req);
    assign grant_if   = bus.if_req && (!bus.dm_req || at_limit);
    assign last_wait  = (state == WAIT) && (lat_cnt == LAT_W'(1));
    // Halt freezes the starvation count: no clearing while halted in IDLE.
    assign starve_inc = grant && !grant_if && bus.if_req;
    assign starve_clr = (grant && grant_if) || ((state == IDLE) && !halt && !bus.if_req);

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock    (clock),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    // State register, grant latches, latency down-counter and read-data capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWNER_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                if (grant_if) begin
                    owner  <= OWNER_IF;
                    we_q   <= 1'b0;
                    addr_q <= bus.if_addr;
                end else begin
                    owner   <= OWNER_DM;
                    we_q    <= bus.dm_we;
                    addr_q  <= bus.dm_addr;
                    wdata_q <= bus.dm_wdata;
                end
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_W'(MEM_LATENCY);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            // Writes leave both read-data registers untouched.
            if (last_wait && !we_q) begin
                if (owner == OWNER_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // Next-state logic and decoded strobes.
    always_comb begin
        state_nxt  = state;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.if_ack = 1'b0;
        bus.dm_ack = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (last_wait) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.if_ack = (owner == OWNER_IF);
                bus.dm_ack = (owner == OWNER_DM);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at latency 3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed from the cycle-level behaviour of the arbiter.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset;
    logic halt_a;
    logic halt_b;
    logic busy_a;
    logic busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .STARVE_LIMIT(4)
    ) u_dut_a (
        .clock (clock),
        .reset (reset),
        .halt  (halt_a),
        .busy  (busy_a),
        .bus   (bus_a)
    );

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3), .STARVE_LIMIT(4)
    ) u_dut_b (
        .clock (clock),
        .reset (reset),
        .halt  (halt_b),
        .busy  (busy_b),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string exp_order;
        int    ngrant;
        int    nack;
        logic [7:0] got_owner;

        reset  = 1'b1;
        halt_a = 1'b0;
        halt_b = 1'b0;
        bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.dm_req = 0; bus_a.dm_we = 0;
        bus_a.dm_addr = '0; bus_a.dm_wdata = '0; bus_a.mem_rdata = '0;
        bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.dm_req = 0; bus_b.dm_we = 0;
        bus_b.dm_addr = '0; bus_b.dm_wdata = '0; bus_b.mem_rdata = '0;
        step(2);
        check_eq("rst_busy",     busy_a, 0);
        check_eq("rst_mem_en",   bus_a.mem_en, 0);
        check_eq("rst_acks",     {bus_a.if_ack, bus_a.dm_ack}, 0);
        check_eq("rst_mem_addr", bus_a.mem_addr, 0);
        check_eq("rst_rdata",    {bus_a.if_rdata, bus_a.dm_rdata}, 0);
        reset = 1'b0;
        step();

        // 1: single fetch
        bus_a.if_req = 1; bus_a.if_addr = 16'h0010; bus_a.mem_rdata = 16'hBEEF;
        step();
        check_eq("t1_mem_en",   bus_a.mem_en, 1);
        check_eq("t1_mem_addr", bus_a.mem_addr, 16'h0010);
        check_eq("t1_mem_we",   bus_a.mem_we, 0);
        step();
        check_eq("t1_mem_en_once", bus_a.mem_en, 0);
        check_eq("t1_no_early_ack", bus_a.if_ack, 0);
        step();
        check_eq("t1_if_ack",   bus_a.if_ack, 1);
        check_eq("t1_if_rdata", bus_a.if_rdata, 16'hBEEF);
        bus_a.if_req = 0;
        step();
        check_eq("t1_ack_pulse", bus_a.if_ack, 0);
        check_eq("t1_idle",      busy_a, 0);

        // 2: simultaneous requests, data write wins first
        bus_a.if_req = 1; bus_a.if_addr = 16'h0020;
        bus_a.dm_req = 1; bus_a.dm_we = 1; bus_a.dm_addr = 16'h8000; bus_a.dm_wdata = 16'h1234;
        step();
        check_eq("t2_mem_en",    bus_a.mem_en, 1);
        check_eq("t2_mem_we",    bus_a.mem_we, 1);
        check_eq("t2_mem_addr",  bus_a.mem_addr, 16'h8000);
        check_eq("t2_mem_wdata", bus_a.mem_wdata, 16'h1234);
        step(2);
        check_eq("t2_dm_ack",    bus_a.dm_ack, 1);
        check_eq("t2_if_not_ack", bus_a.if_ack, 0);
        check_eq("t2_write_keeps_dm_rdata", bus_a.dm_rdata, 0);
        bus_a.dm_req = 0; bus_a.dm_we = 0;
        step();
        check_eq("t2_idle_gap", bus_a.mem_en, 0);
        step();
        check_eq("t2_if_mem_en",   bus_a.mem_en, 1);
        check_eq("t2_if_mem_addr", bus_a.mem_addr, 16'h0020);
        bus_a.mem_rdata = 16'h1111;
        step(2);
        check_eq("t2_if_ack",    bus_a.if_ack, 1);
        check_eq("t2_dm_no_ack", bus_a.dm_ack, 0);
        check_eq("t2_if_rdata",  bus_a.if_rdata, 16'h1111);
        bus_a.if_req = 0;
        step();

        // 3: both held continuously, fetch forced every fifth grant
        bus_a.if_req = 1; bus_a.if_addr = 16'h0020;
        bus_a.dm_req = 1; bus_a.dm_we = 0; bus_a.dm_addr = 16'h8000;
        exp_order = "DDDDIDDDDI";
        ngrant = 0;
        for (int c = 0; c < 60 && ngrant < 10; c++) begin
            step();
            check_eq("t3_ack_excl", bus_a.if_ack & bus_a.dm_ack, 0);
            if (bus_a.mem_en) begin
                got_owner = (bus_a.mem_addr == 16'h0020) ? 8'h49 : 8'h44;
                check_eq("t3_grant_order", got_owner, exp_order[ngrant]);
                ngrant++;
            end
        end
        check_eq("t3_grant_count", ngrant, 10);
        // dropping req mid-access still completes the in-flight fetch
        bus_a.if_req = 0; bus_a.dm_req = 0;
        nack = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            nack += int'(bus_a.if_ack);
            check_eq("t3_no_dm_ack", bus_a.dm_ack, 0);
        end
        check_eq("t3_late_if_ack", nack, 1);

        // 4: halt raised during WAIT of a data read
        bus_a.dm_req = 1; bus_a.dm_we = 0; bus_a.dm_addr = 16'h8002; bus_a.mem_rdata = 16'h5A5A;
        step();
        check_eq("t4_mem_en",   bus_a.mem_en, 1);
        check_eq("t4_mem_addr", bus_a.mem_addr, 16'h8002);
        bus_a.if_req = 1; bus_a.if_addr = 16'h0020;
        step();
        halt_a = 1;
        step();
        check_eq("t4_dm_ack",   bus_a.dm_ack, 1);
        check_eq("t4_dm_rdata", bus_a.dm_rdata, 16'h5A5A);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("t4_halt_no_mem_en", bus_a.mem_en, 0);
            check_eq("t4_halt_idle",      busy_a, 0);
        end
        halt_a = 0;
        step();
        check_eq("t4_resume_mem_en", bus_a.mem_en, 1);
        check_eq("t4_resume_dm",     bus_a.mem_addr, 16'h8002);
        step(2);
        check_eq("t4_dm_ack2", bus_a.dm_ack, 1);
        bus_a.dm_req = 0;
        step(2);
        check_eq("t4_if_mem_en",   bus_a.mem_en, 1);
        check_eq("t4_if_mem_addr", bus_a.mem_addr, 16'h0020);
        step(2);
        check_eq("t4_if_ack",   bus_a.if_ack, 1);
        check_eq("t4_if_rdata", bus_a.if_rdata, 16'h5A5A);
        bus_a.if_req = 0;
        step();

        // 5: reset during WAIT drops the access
        bus_a.dm_req = 1; bus_a.dm_addr = 16'h8004; bus_a.mem_rdata = 16'h7777;
        step();
        check_eq("t5_mem_en", bus_a.mem_en, 1);
        step();
        reset = 1;
        step();
        check_eq("t5_busy",     busy_a, 0);
        check_eq("t5_acks",     {bus_a.if_ack, bus_a.dm_ack}, 0);
        check_eq("t5_rdata",    {bus_a.if_rdata, bus_a.dm_rdata}, 0);
        check_eq("t5_mem_addr", bus_a.mem_addr, 0);
        reset = 0; bus_a.dm_req = 0;
        nack = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            nack += int'(bus_a.dm_ack) + int'(bus_a.if_ack);
        end
        check_eq("t5_no_ack_dropped", nack, 0);
        bus_a.if_req = 1; bus_a.if_addr = 16'h0030; bus_a.mem_rdata = 16'h4321;
        step();
        check_eq("t5_fresh_mem_en",   bus_a.mem_en, 1);
        check_eq("t5_fresh_mem_addr", bus_a.mem_addr, 16'h0030);
        step(2);
        check_eq("t5_fresh_ack",   bus_a.if_ack, 1);
        check_eq("t5_fresh_rdata", bus_a.if_rdata, 16'h4321);
        bus_a.if_req = 0;
        step();

        // 6: latency 3, read data valid for exactly one cycle
        bus_b.dm_req = 1; bus_b.dm_we = 0; bus_b.dm_addr = 16'h00FF; bus_b.mem_rdata = 16'hFFFF;
        step();
        check_eq("t6_mem_en",   bus_b.mem_en, 1);
        check_eq("t6_mem_addr", bus_b.mem_addr, 16'h00FF);
        step();
        check_eq("t6_no_ack_c2", bus_b.dm_ack, 0);
        step();
        check_eq("t6_no_ack_c3", bus_b.dm_ack, 0);
        step();
        check_eq("t6_no_ack_c4", bus_b.dm_ack, 0);
        bus_b.mem_rdata = 16'hA5A5;
        step();
        bus_b.mem_rdata = 16'hFFFF;
        check_eq("t6_dm_ack",   bus_b.dm_ack, 1);
        check_eq("t6_dm_rdata", bus_b.dm_rdata, 16'hA5A5);
        bus_b.dm_req = 0;
        step();
        check_eq("t6_ack_pulse", bus_b.dm_ack, 0);
        check_eq("t6_rdata_held", bus_b.dm_rdata, 16'hA5A5);
        check_eq("t6_idle", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
